exec_wb_stage: RTL and testbench

EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

---
 rtl/exec_wb_stage_if.sv | 36 +++
 rtl/exec_wb_stage.sv | 113 +++++++++++
 tb/tb_exec_wb_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/exec_wb_stage_if.sv
// Handshake and result bus between the ALU, the execute/writeback buffer and
// the writeback stage. The stage uses the slave modport. The environment
// that feeds and drains the stage uses the master modport.
interface exec_wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_c;
  logic              in_z;
  logic              in_n;
  logic [RD_W-1:0]   in_rd;
  logic              in_wr_en;
  logic              in_set_flags;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_wr_en;
  logic [2:0]        flags_nzc;

  modport slave (
    input  in_valid, in_result, in_c, in_z, in_n, in_rd, in_wr_en,
           in_set_flags, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wr_en, flags_nzc
  );

  modport master (
    output in_valid, in_result, in_c, in_z, in_n, in_rd, in_wr_en,
           in_set_flags, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wr_en, flags_nzc
  );
endinterface

// File: rtl/exec_wb_stage.sv
// Execute-to-writeback buffer with the architectural flag register {N,Z,C}.
// Configuration macro EXWB_SKID_EN:
//   defined   -> 2-entry skid buffer, in_ready depends only on registered occupancy
//   undefined -> single register, in_ready = !out_valid || out_ready (combinational)
// Flush discards buffered and incoming entries. It leaves the flags untouched.
module exec_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  exec_wb_stage_if.slave bus
);

  logic              w_accept;
  logic              w_retire;
  logic              w_in_ready;
  logic              w_out_valid;

  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_res0;
  logic [RD_W-1:0]   r_rd0;
  logic              r_wr0;
`ifdef EXWB_SKID_EN
  logic [DATA_W-1:0] r_res1;
  logic [RD_W-1:0]   r_rd1;
  logic              r_wr1;
`endif
  logic [2:0]        r_flags;

  assign w_out_valid = (r_count != 2'd0);
`ifdef EXWB_SKID_EN
  assign w_in_ready  = (r_count != 2'd2);
`else
  assign w_in_ready  = !w_out_valid || bus.out_ready;
`endif

  // Flush overrides both accept and retire.
  assign w_accept = bus.in_valid && w_in_ready && !bus.flush;
  assign w_retire = w_out_valid && bus.out_ready && !bus.flush;

  // Occupancy: a simultaneous accept and retire leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (bus.flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + {1'b0, w_accept} - {1'b0, w_retire};
    end
  end

  // Head slot: this is the entry presented downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res0 <= '0;
      r_rd0  <= '0;
      r_wr0  <= 1'b0;
    end else if (!bus.flush) begin
`ifdef EXWB_SKID_EN
      // On retire, the second slot moves up when it is occupied.
      // Otherwise a same-edge accept goes straight into the head.
      if (w_retire && r_count == 2'd2) begin
        r_res0 <= r_res1;
        r_rd0  <= r_rd1;
        r_wr0  <= r_wr1;
      end else if (w_accept && (w_retire || r_count == 2'd0)) begin
        r_res0 <= bus.in_result;
        r_rd0  <= bus.in_rd;
        r_wr0  <= bus.in_wr_en;
      end
`else
      if (w_accept) begin
        r_res0 <= bus.in_result;
        r_rd0  <= bus.in_rd;
        r_wr0  <= bus.in_wr_en;
      end
`endif
    end
  end

`ifdef EXWB_SKID_EN
  // Second slot: it is filled only when the head is occupied and stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res1 <= '0;
      r_rd1  <= '0;
      r_wr1  <= 1'b0;
    end else if (w_accept && !w_retire && r_count == 2'd1) begin
      r_res1 <= bus.in_result;
      r_rd1  <= bus.in_rd;
      r_wr1  <= bus.in_wr_en;
    end
  end
`endif

  // Flags update when the entry is accepted. They do not wait for retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else if (w_accept && bus.in_set_flags) begin
      r_flags <= {bus.in_n, bus.in_z, bus.in_c};
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_result = w_out_valid ? r_res0 : '0;
  assign bus.out_rd     = w_out_valid ? r_rd0  : '0;
  assign bus.out_wr_en  = w_out_valid && r_wr0;
  assign bus.flags_nzc  = r_flags;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Bench for exec_wb_stage. It drives directed vectors and compares the outputs
// on every cycle against a queue-based model of the buffer and the flags.
// Literal checks pin the expected values of key cycles.
module tb_exec_wb_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exec_wb_stage_if #(.DATA_W(32), .RD_W(4)) bus ();

  exec_wb_stage #(.DATA_W(32), .RD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        wr;
  } ent_t;

  ent_t       mq[$];
  logic [2:0] mflags;

  function automatic logic m_in_ready();
`ifdef EXWB_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || (bus.out_ready === 1'b1);
`endif
  endfunction

  always @(negedge rst_n) begin
    mq.delete();
    mflags = 3'b000;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      logic acc, ret;
      ent_t e;
      acc = bus.in_valid && m_in_ready() && !bus.flush;
      ret = (mq.size() != 0) && bus.out_ready && !bus.flush;
      e.res = bus.in_result;
      e.rd  = bus.in_rd;
      e.wr  = bus.in_wr_en;
      if (bus.flush) mq.delete();
      else begin
        if (ret) void'(mq.pop_front());
        if (acc) mq.push_back(e);
      end
      if (acc && bus.in_set_flags) mflags = {bus.in_n, bus.in_z, bus.in_c};
    end
  end

  // This process compares every output with the model on every negedge.
  always @(negedge clk) begin
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("m_out_valid",  {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
    chk("m_out_result", bus.out_result,          h.res);
    chk("m_out_rd",     {28'd0, bus.out_rd},     {28'd0, h.rd});
    chk("m_out_wr_en",  {31'd0, bus.out_wr_en},  {31'd0, h.wr});
    chk("m_flags",      {29'd0, bus.flags_nzc},  {29'd0, mflags});
    chk("m_in_ready",   {31'd0, bus.in_ready},   {31'd0, m_in_ready()});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] res, input logic [3:0] rd, input logic wr,
                      input logic sf, input logic n, input logic z, input logic c);
    bus.in_valid     = 1'b1;
    bus.in_result    = res;
    bus.in_rd        = rd;
    bus.in_wr_en     = wr;
    bus.in_set_flags = sf;
    bus.in_n         = n;
    bus.in_z         = z;
    bus.in_c         = c;
  endtask

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.in_result    = '0;
    bus.in_rd        = '0;
    bus.in_wr_en     = 1'b0;
    bus.in_set_flags = 1'b0;
    bus.in_n         = 1'b0;
    bus.in_z         = 1'b0;
    bus.in_c         = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    idle();

    // reset state, then the first accept right after release
    tick();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_flags",     {29'd0, bus.flags_nzc}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    rst_n = 1'b1;
    push(32'h55, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("first_valid",  {31'd0, bus.out_valid}, 32'd1);
    chk("first_result", bus.out_result, 32'h55);
    chk("first_rd",     {28'd0, bus.out_rd}, 32'd3);

    // streaming and flags
    push(32'h1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("stream1", bus.out_result, 32'h1);
    chk("flags_set", {29'd0, bus.flags_nzc}, 32'd5);
    push(32'h2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("stream2", bus.out_result, 32'h2);
    chk("flags_kept", {29'd0, bus.flags_nzc}, 32'd5);
    push(32'h3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stream3", bus.out_result, 32'h3);
    chk("wr0_passes", {31'd0, bus.out_wr_en}, 32'd0);
    idle();
    tick();
    chk("drained_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("drained_result", bus.out_result, 32'd0);

    // backpressure
    bus.out_ready = 1'b0;
    push(32'hA, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_headA", bus.out_result, 32'hA);
`ifdef EXWB_SKID_EN
    chk("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
`else
    chk("bp_ready1", {31'd0, bus.in_ready}, 32'd0);
`endif
    push(32'hB, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_holdA1", bus.out_result, 32'hA);
    chk("bp_ready2", {31'd0, bus.in_ready}, 32'd0);
    idle();
    tick();
    chk("bp_holdA2", bus.out_result, 32'hA);
    bus.out_ready = 1'b1;
    push(32'hC, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef EXWB_SKID_EN
    chk("rel_ready", {31'd0, bus.in_ready}, 32'd0);
`else
    chk("rel_ready", {31'd0, bus.in_ready}, 32'd1);
`endif
    tick();
`ifdef EXWB_SKID_EN
    chk("rel_next", bus.out_result, 32'hB);
`else
    chk("rel_next", bus.out_result, 32'hC);
`endif
    idle();
    tick();
    chk("rel_empty", {31'd0, bus.out_valid}, 32'd0);

    // flush with the buffer loaded
    bus.out_ready = 1'b0;
    push(32'h11, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("fl_head", bus.out_result, 32'h11);
    chk("fl_flags0", {29'd0, bus.flags_nzc}, 32'd3);
    push(32'h22, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl_head2", bus.out_result, 32'h11);
    bus.flush = 1'b1;
    push(32'h33, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_flags", {29'd0, bus.flags_nzc}, 32'd3);
    bus.flush = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    tick();
    chk("fl_nothing", {31'd0, bus.out_valid}, 32'd0);

    // reset asserted in mid-cycle with an entry in flight
    bus.out_ready = 1'b0;
    push(32'h44, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mr_head",  bus.out_result, 32'h44);
    chk("mr_flags", {29'd0, bus.flags_nzc}, 32'd4);
    push(32'h45, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("mr_flags0", {29'd0, bus.flags_nzc}, 32'd0);
    chk("mr_result", bus.out_result, 32'd0);
    tick();
    rst_n = 1'b1;
    idle();
    tick();
    chk("mr_no_replay", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    push(32'h66, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_rst", bus.out_result, 32'h66);
    idle();
    tick();
    chk("end_empty", {31'd0, bus.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
